gaussian_stream_ctrl: RTL and testbench
=======================================

Name: gaussian_stream_ctrl

Overview:
Frame sequencer for the two-stage separable 5x5 Gaussian datapath (horizontal 5-tap, then vertical 5-tap over line delays). It accepts a raster pixel stream with valid/ready and drives the datapath's clock-enable, synchronous clear and pixel input. After the last input pixel it flushes the pipeline with zero pixels. It emits exactly IMG_W*IMG_H centre-aligned output pixels with raster markers and border flags, and back-pressures the source when the sink stalls.

Parameters:
IMG_W, 400, pixels per line; must equal the datapath line-delay length.
IMG_H, 300, lines per frame.
LAT, 2*IMG_W+2, datapath advances from pixel entry to its centred output (localparam, not overridable).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a frame when IDLE
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse in DONE
in_valid  in  1  source pixel valid
in_ready  out  1  pixel accepted when in_valid & in_ready
in_data  in  8  source pixel
gauss_din  out  8  datapath pixel input
gauss_ce  out  1  datapath clock enable (one advance per cycle high)
gauss_reset  out  1  datapath synchronous clear
gauss_dout  in  8  datapath output, combinational from gauss_din and delay state
out_valid  out  1  output pixel valid
out_ready  in  1  sink ready
out_data  out  8  filtered pixel
out_sof  out  1  first pixel of frame (qualified by out_valid)
out_eol  out  1  last pixel of line
out_eof  out  1  last pixel of frame
out_border  out  1  5x5 window of this pixel crosses an image edge

Behaviour:
- States: IDLE -> CLEAR (start) -> RUN -> FLUSH -> DONE -> IDLE. start outside IDLE is ignored.
- CLEAR: exactly one cycle; gauss_reset=1, gauss_ce=0. gauss_reset = reset | (state==CLEAR).
- Advance counter adv_cnt counts gauss_ce cycles from 0. emit = (adv_cnt >= LAT).
- RUN: src = in_valid. FLUSH: src = 1. Otherwise src = 0.
- gauss_ce = src & (!emit | out_ready).
- in_ready = (state==RUN) & (!emit | out_ready). in_ready is 0 in every other state.
- gauss_din = in_data in RUN; 8'd0 in FLUSH.
- out_valid = src & emit. out_valid never depends on out_ready.
- out_data = gauss_dout, combinational, with zero added latency. Holds stable while stalled, because the datapath does not advance.
- RUN -> FLUSH on the cycle the IMG_W*IMG_H-th pixel is accepted. FLUSH -> DONE on the LAT-th flush advance. DONE lasts one cycle.
- Total advances per frame: IMG_W*IMG_H + LAT. Total out_valid&out_ready transfers: exactly IMG_W*IMG_H.
- Output coordinates out_col/out_row:
  - Reset to 0 in CLEAR; advance on each output transfer.
  - out_col wraps at IMG_W-1 and increments out_row.
  - out_sof = (col==0 & row==0). out_eol = (col==IMG_W-1). out_eof = out_eol & (row==IMG_H-1).
- out_border = col<2 | col>=IMG_W-2 | row<2 | row>=IMG_H-2.
- Edge case IMG_W*IMG_H < LAT: emission starts during FLUSH. The same rules apply.
- Counter widths: $clog2 of the maximum value + 1. No counter may wrap within a frame.
- Reset (including mid-frame):
  - State returns to IDLE and all counters clear.
  - busy, frame_done, in_ready, gauss_ce, out_valid = 0; gauss_reset = 1.
  - gauss_din and out flags are don't-care while invalid but must not be X.

Optional Feature:
GAUSS_BORDER_ZERO_EN:
- Defined: out_data is forced to 8'd0 whenever out_border=1.
- Undefined: out_data = gauss_dout for all pixels.
- out_border is generated in both builds.

Decomposition:
- Package gaussian_pkg: state enum (IDLE, CLEAR, RUN, FLUSH, DONE), kernel constants K1=6/K2=58/K3=128, function gauss_lat(w) = 2*w+2.
- One sub-module, raster_counter: col/row counter with enable, clear, wrap, first/eol/eof outputs. It is instantiated for output coordinates; the input pixel count uses a plain counter.

Test Plan:
- Reset held 3 cycles -> busy=0, in_ready=0, gauss_ce=0, out_valid=0, gauss_reset=1. Release, then start -> gauss_reset=1 for exactly one cycle (CLEAR).
- IMG_W=8, IMG_H=6 (LAT=18), constant pixel 100, in_valid=1, out_ready=1 -> first out_valid on the 19th gauss_ce cycle with out_sof=1; 48 transfers; interior out_data=100; frame_done pulses once after the 66th advance.
- Same frame with out_ready=0 for 5 cycles after the 10th output -> gauss_ce=0, in_ready=0, out_valid=1 held, out_data stable; still 48 outputs, no loss or duplication.
- Random in_valid gaps (~50%) with a ramp image -> output sequence bit-identical to the gap-free run; out_eol on every 8th transfer; out_eof only on the 48th.
- reset asserted mid-RUN after 20 pixels, then a new start -> IDLE on the next cycle; the new frame produces 48 correct outputs. start pulsed while busy is ignored.
- Both builds, IMG_W=8, IMG_H=6 -> out_border=1 on 40 pixels, 0 on 8. With GAUSS_BORDER_ZERO_EN those 40 pixels read 0; without it they read raw gauss_dout.

Source files
------------

// File: rtl/gaussian_pkg.sv
// Shared types and constants for the separable 5x5 Gaussian stream controller.
package gaussian_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StFlush,
    StDone
  } gauss_state_e;

  // Binomial-like 5-tap kernel; taps sum to 256 so each pass is a plain >> 8.
  localparam int unsigned K1 = 6;
  localparam int unsigned K2 = 58;
  localparam int unsigned K3 = 128;

  function automatic int unsigned gauss_lat(input int unsigned w);
    return 2 * w + 2;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row raster position counter with synchronous clear, wrap and line/frame markers.
module raster_counter
  import gaussian_pkg::*;
#(
  parameter int unsigned Width  = 400,
  parameter int unsigned Height = 300,
  localparam int unsigned ColW  = cnt_width(Width - 1),
  localparam int unsigned RowW  = cnt_width(Height - 1)
) (
  input  logic            clk_i,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [ColW-1:0] col_o,
  output logic [RowW-1:0] row_o,
  output logic            first_o,
  output logic            eol_o,
  output logic            eof_o
);

  localparam logic [ColW-1:0] ColLast = ColW'(Width - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(Height - 1);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (en_i) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o   = col_q;
  assign row_o   = row_q;
  assign first_o = (col_q == '0) && (row_q == '0);
  assign eol_o   = (col_q == ColLast);
  assign eof_o   = (col_q == ColLast) && (row_q == RowLast);

endmodule

// File: rtl/gaussian_stream_ctrl.sv
// Frame sequencer for the separable 5x5 Gaussian datapath: feeds pixels, flushes, tags outputs.
// Optional build macro GAUSS_BORDER_ZERO_EN forces border output pixels to zero.
module gaussian_stream_ctrl
  import gaussian_pkg::*;
#(
  parameter int unsigned IMG_W = 400,
  parameter int unsigned IMG_H = 300
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       frame_done_o,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_data_i,
  output logic [7:0] gauss_din_o,
  output logic       gauss_ce_o,
  output logic       gauss_reset_o,
  input  logic [7:0] gauss_dout_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_data_o,
  output logic       out_sof_o,
  output logic       out_eol_o,
  output logic       out_eof_o,
  output logic       out_border_o
);

  localparam int unsigned LAT     = gauss_lat(IMG_W);
  localparam int unsigned NPIX    = IMG_W * IMG_H;
  localparam int unsigned AdvW    = cnt_width(NPIX + LAT);
  localparam int unsigned PixW    = cnt_width(NPIX);
  localparam int unsigned ColW    = cnt_width(IMG_W - 1);
  localparam int unsigned RowW    = cnt_width(IMG_H - 1);

  localparam logic [AdvW-1:0] AdvLat  = AdvW'(LAT);
  localparam logic [AdvW-1:0] AdvLast = AdvW'(NPIX + LAT - 1);
  localparam logic [PixW-1:0] PixLast = PixW'(NPIX - 1);
  localparam logic [ColW-1:0] ColLo   = ColW'(2);
  localparam logic [ColW-1:0] ColHi   = ColW'(IMG_W - 2);
  localparam logic [RowW-1:0] RowLo   = RowW'(2);
  localparam logic [RowW-1:0] RowHi   = RowW'(IMG_H - 2);

  gauss_state_e    state_q, state_d;
  logic [AdvW-1:0] adv_q;
  logic [PixW-1:0] pix_q;
  logic            busy_q, done_q;

  logic            in_run, in_flush, src, emit, may_advance;
  logic            accept, xfer, last_pix, last_adv;
  logic [ColW-1:0] out_col;
  logic [RowW-1:0] out_row;

  always_comb begin
    in_run      = (state_q == StRun);
    in_flush    = (state_q == StFlush);
    src         = in_run ? in_valid_i : in_flush;
    emit        = (adv_q >= AdvLat);
    // Once outputs are being produced, an advance would overwrite the pending output.
    may_advance = !emit || out_ready_i;
    gauss_ce_o  = src && may_advance;
    in_ready_o  = in_run && may_advance;
    out_valid_o = src && emit;
    gauss_din_o = in_run ? in_data_i : 8'd0;
    accept      = in_valid_i && in_ready_o;
    xfer        = out_valid_o && out_ready_i;
    last_pix    = accept && (pix_q == PixLast);
    last_adv    = gauss_ce_o && in_flush && (adv_q == AdvLast);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StClear;
      StClear: state_d = StRun;
      StRun:   if (last_pix) state_d = StFlush;
      StFlush: if (last_adv) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      adv_q   <= '0;
      pix_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
      if (state_q == StClear) begin
        adv_q <= '0;
        pix_q <= '0;
      end else begin
        if (gauss_ce_o) adv_q <= adv_q + 1'b1;
        if (accept)     pix_q <= pix_q + 1'b1;
      end
    end
  end

  assign busy_o        = busy_q;
  assign frame_done_o  = done_q;
  assign gauss_reset_o = reset_i || (state_q == StClear);

  raster_counter #(
    .Width  (IMG_W),
    .Height (IMG_H)
  ) u_out_pos (
    .clk_i   (clk_i),
    .clr_i   (reset_i || (state_q == StClear)),
    .en_i    (xfer),
    .col_o   (out_col),
    .row_o   (out_row),
    .first_o (out_sof_o),
    .eol_o   (out_eol_o),
    .eof_o   (out_eof_o)
  );

  assign out_border_o = (out_col < ColLo) || (out_col >= ColHi) ||
                        (out_row < RowLo) || (out_row >= RowHi);

`ifdef GAUSS_BORDER_ZERO_EN
  assign out_data_o = out_border_o ? 8'd0 : gauss_dout_i;
`else
  assign out_data_o = gauss_dout_i;
`endif

endmodule

// File: tb/tb_gaussian_stream_ctrl.sv
// Self-checking bench for gaussian_stream_ctrl with a behavioural 5x5 Gaussian datapath stub.
module tb_gaussian_stream_ctrl;
  import gaussian_pkg::*;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NPIX = W * H;
  localparam int HIST = 4 * W + 4;

`ifdef GAUSS_BORDER_ZERO_EN
  localparam bit ZeroBorder = 1'b1;
`else
  localparam bit ZeroBorder = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, in_valid, out_ready;
  logic [7:0] in_data, gauss_din, gauss_dout, out_data;
  logic       busy, frame_done, in_ready, gauss_ce, gauss_reset;
  logic       out_valid, out_sof, out_eol, out_eof, out_border;

  always #5 clk = ~clk;

  gaussian_stream_ctrl #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .busy_o        (busy),
    .frame_done_o  (frame_done),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .gauss_din_o   (gauss_din),
    .gauss_ce_o    (gauss_ce),
    .gauss_reset_o (gauss_reset),
    .gauss_dout_i  (gauss_dout),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_sof_o     (out_sof),
    .out_eol_o     (out_eol),
    .out_eof_o     (out_eof),
    .out_border_o  (out_border)
  );

  function automatic int unsigned wt(input int i);
    if (i == 2) return K3;
    if (i == 1 || i == 3) return K2;
    return K1;
  endfunction

  // Datapath stub: raster history shift register, output combinational from din + history.
  logic [7:0] hist [HIST];

  always_ff @(posedge clk) begin
    if (gauss_reset) begin
      for (int i = 0; i < HIST; i++) hist[i] <= 8'd0;
    end else if (gauss_ce) begin
      hist[0] <= gauss_din;
      for (int i = 1; i < HIST; i++) hist[i] <= hist[i-1];
    end
  end

  function automatic logic [7:0] dp_eval(input logic [7:0] din, input logic [7:0] h [HIST]);
    int unsigned acc;
    int          k;
    logic [7:0]  tap;
    acc = 0;
    for (int dr = 0; dr < 5; dr++) begin
      for (int dc = 0; dc < 5; dc++) begin
        k   = (4 - dr) * W + (4 - dc);
        tap = (k == 0) ? din : h[k-1];
        acc += wt(dr) * wt(dc) * int'(tap);
      end
    end
    return 8'((acc + 32768) >> 16);
  endfunction

  always_comb gauss_dout = dp_eval(gauss_din, hist);

  // Reference: frame pixels as a flat raster, zero outside the frame.
  logic [7:0] img [NPIX];

  function automatic bit is_border(input int p);
    int r, c;
    r = p / W;
    c = p % W;
    return (r < 2) || (r >= H - 2) || (c < 2) || (c >= W - 2);
  endfunction

  function automatic logic [7:0] exp_pix(input int p);
    int unsigned acc;
    int          q;
    if (ZeroBorder && is_border(p)) return 8'd0;
    acc = 0;
    for (int dr = -2; dr <= 2; dr++) begin
      for (int dc = -2; dc <= 2; dc++) begin
        q = p + dr * W + dc;
        if (q >= 0 && q < NPIX) acc += wt(dr + 2) * wt(dc + 2) * int'(img[q]);
      end
    end
    return 8'((acc + 32768) >> 16);
  endfunction

  int errors = 0;
  int checks = 0;

  logic [7:0] got_d   [NPIX];
  logic [7:0] ref_d   [NPIX];
  bit         got_sof [NPIX];
  bit         got_eol [NPIX];
  bit         got_eof [NPIX];
  bit         got_bdr [NPIX];
  int n_out, n_ce, n_done, done_ce, first_ce, stall_seen, stall_bad, n_greset;
  bit timed_out;

  task automatic fill_img(input int mode);
    for (int i = 0; i < NPIX; i++) begin
      if (mode == 0)      img[i] = 8'd100;
      else if (mode == 1) img[i] = 8'((i * 7 + 3) & 255);
      else                img[i] = 8'($urandom_range(255));
    end
  endtask

  task automatic run_frame(input int gap_pct, input int stall_after, input int stall_len,
                           input int restart_at);
    int sent, stall_left, cyc, post;
    bit stalled_once;
    logic [7:0] held;
    sent = 0; stall_left = 0; cyc = 0; post = 0; stalled_once = 0; held = 8'd0;
    n_out = 0; n_ce = 0; n_done = 0; done_ce = -1; first_ce = -1;
    stall_seen = 0; stall_bad = 0; n_greset = 0;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 2000 && post < 3) begin
      @(negedge clk);
      start = (cyc == restart_at);
      if (stall_after >= 0 && !stalled_once && n_out == stall_after) begin
        stall_left   = stall_len;
        stalled_once = 1'b1;
      end
      out_ready = (stall_left == 0);
      in_valid  = (sent < NPIX) && (int'($urandom_range(99)) >= gap_pct);
      in_data   = img[(sent < NPIX) ? sent : 0];
      #1;
      if (gauss_reset) n_greset++;
      if (stall_left > 0) begin
        stall_seen++;
        if (stall_left == stall_len) held = out_data;
        else if (out_data !== held) stall_bad++;
        if (gauss_ce !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) stall_bad++;
        stall_left--;
      end
      if (gauss_ce) n_ce++;
      if (out_valid && out_ready) begin
        if (n_out == 0) first_ce = n_ce;
        if (n_out < NPIX) begin
          got_d[n_out]   = out_data;
          got_sof[n_out] = out_sof;
          got_eol[n_out] = out_eol;
          got_eof[n_out] = out_eof;
          got_bdr[n_out] = out_border;
        end
        n_out++;
      end
      if (in_valid && in_ready) sent++;
      if (frame_done) begin
        n_done++;
        done_ce = n_ce;
      end
      if (n_done > 0) post++;
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    timed_out = (n_done == 0);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || gauss_ce !== 1'b0 || out_valid !== 1'b0 ||
        gauss_reset !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b in_ready=%b ce=%b out_valid=%b greset=%b done=%b, want 0 0 0 0 1 0",
               busy, in_ready, gauss_ce, out_valid, gauss_reset, frame_done);
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    #1;
    checks++;
    if (gauss_reset !== 1'b0) begin
      errors++;
      $display("FAIL idle_greset: got %b want 0", gauss_reset);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (gauss_reset !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_cycle: greset=%b busy=%b want 1 1", gauss_reset, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (gauss_reset !== 1'b0) begin
      errors++;
      $display("FAIL clear_one_cycle: greset=%b want 0", gauss_reset);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    fill_img(0);
    run_frame(0, -1, 0, -1);
    checks++;
    if (timed_out || n_out != NPIX || n_done != 1) begin
      errors++;
      $display("FAIL basic_counts: outputs=%0d dones=%0d timeout=%0b want %0d 1 0",
               n_out, n_done, timed_out, NPIX);
    end
    checks++;
    if (first_ce != 19 || got_sof[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_first: first valid on ce %0d sof=%b want 19 1", first_ce, got_sof[0]);
    end
    checks++;
    if (done_ce != 66 || n_ce != 66) begin
      errors++;
      $display("FAIL basic_done: done after ce %0d total ce %0d want 66 66", done_ce, n_ce);
    end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (got_d[i] !== exp_pix(i) || (!is_border(i) && got_d[i] !== 8'd100)) begin
        errors++;
        $display("FAIL basic_data[%0d]: got %0d want %0d", i, got_d[i], exp_pix(i));
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_stall;
    fill_img(0);
    run_frame(0, 10, 5, -1);
    checks++;
    if (stall_seen != 5 || stall_bad != 0) begin
      errors++;
      $display("FAIL stall_hold: stall cycles %0d violations %0d want 5 0", stall_seen, stall_bad);
    end
    checks++;
    if (timed_out || n_out != NPIX || n_ce != 66) begin
      errors++;
      $display("FAIL stall_counts: outputs=%0d ce=%0d want %0d 66", n_out, n_ce, NPIX);
    end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (got_d[i] !== exp_pix(i)) begin
        errors++;
        $display("FAIL stall_data[%0d]: got %0d want %0d", i, got_d[i], exp_pix(i));
      end
    end
  endtask

  task automatic test_gaps;
    fill_img(1);
    run_frame(0, -1, 0, -1);
    for (int i = 0; i < NPIX; i++) ref_d[i] = got_d[i];
    run_frame(50, -1, 0, -1);
    checks++;
    if (timed_out || n_out != NPIX) begin
      errors++;
      $display("FAIL gaps_count: outputs=%0d want %0d", n_out, NPIX);
    end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (got_d[i] !== ref_d[i] || got_d[i] !== exp_pix(i)) begin
        errors++;
        $display("FAIL gaps_data[%0d]: got %0d gapfree %0d want %0d", i, got_d[i], ref_d[i],
                 exp_pix(i));
      end
      checks++;
      if (got_sof[i] !== (i == 0) || got_eol[i] !== (i % W == W - 1) ||
          got_eof[i] !== (i == NPIX - 1)) begin
        errors++;
        $display("FAIL gaps_flags[%0d]: sof/eol/eof=%b%b%b want %b%b%b", i, got_sof[i],
                 got_eol[i], got_eof[i], i == 0, i % W == W - 1, i == NPIX - 1);
      end
    end
  endtask

  task automatic test_random_stall;
    fill_img(2);
    run_frame(30, 20, int'($urandom_range(2, 6)), -1);
    checks++;
    if (timed_out || n_out != NPIX || n_done != 1 || stall_bad != 0) begin
      errors++;
      $display("FAIL rand_counts: outputs=%0d dones=%0d stall_viol=%0d want %0d 1 0",
               n_out, n_done, stall_bad, NPIX);
    end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (got_d[i] !== exp_pix(i)) begin
        errors++;
        $display("FAIL rand_data[%0d]: got %0d want %0d", i, got_d[i], exp_pix(i));
      end
    end
  endtask

  task automatic test_mid_reset;
    int n, cyc;
    fill_img(2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 20 && cyc < 200) begin
      @(negedge clk);
      in_data = img[n]; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) n++;
      cyc++;
    end
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL midreset_feed: accepted %0d want 20", n);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (gauss_reset !== 1'b1) begin
      errors++;
      $display("FAIL midreset_greset: got %b want 1", gauss_reset);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || gauss_ce !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: busy=%b in_ready=%b ce=%b out_valid=%b want 0 0 0 0",
               busy, in_ready, gauss_ce, out_valid);
    end
    reset = 1'b0; in_valid = 1'b0;
    fill_img(1);
    run_frame(0, -1, 0, -1);
    checks++;
    if (timed_out || n_out != NPIX || n_ce != 66) begin
      errors++;
      $display("FAIL midreset_counts: outputs=%0d ce=%0d want %0d 66", n_out, n_ce, NPIX);
    end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (got_d[i] !== exp_pix(i)) begin
        errors++;
        $display("FAIL midreset_data[%0d]: got %0d want %0d", i, got_d[i], exp_pix(i));
      end
    end
  endtask

  task automatic test_start_ignored;
    int mism;
    fill_img(1);
    run_frame(0, -1, 0, 5);
    mism = 0;
    for (int i = 0; i < NPIX; i++) if (got_d[i] !== exp_pix(i)) mism++;
    checks++;
    if (n_greset != 0 || n_out != NPIX || n_done != 1 || mism != 0) begin
      errors++;
      $display("FAIL start_ignored: clears=%0d outputs=%0d dones=%0d bad=%0d want 0 %0d 1 0",
               n_greset, n_out, n_done, mism, NPIX);
    end
  endtask

  task automatic test_border;
    int nb;
    fill_img(2);
    run_frame(0, -1, 0, -1);
    nb = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (got_bdr[i]) nb++;
      checks++;
      if (got_bdr[i] !== is_border(i) || (got_bdr[i] && ZeroBorder && got_d[i] !== 8'd0) ||
          got_d[i] !== exp_pix(i)) begin
        errors++;
        $display("FAIL border[%0d]: flag=%b data=%0d want flag=%b data=%0d", i, got_bdr[i],
                 got_d[i], is_border(i), exp_pix(i));
      end
    end
    checks++;
    if (nb != 40) begin
      errors++;
      $display("FAIL border_count: got %0d want 40", nb);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gaps();
    test_random_stall();
    test_mid_reset();
    test_start_ignored();
    test_border();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
